// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port word SRAM between the IF stage (instruction reads)
// and the MEM stage (data reads/writes). A fixed-latency sequencer grants one
// requester and holds the SRAM for WAIT_CYCLES cycles. It then returns the
// result with a one-cycle ready pulse. The pipeline treats !if_ready and
// !mem_ready as a freeze.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-low reset
//   if_req/if_addr      IF instruction read request and address
//   if_cancel           discard the in-flight IF result (branch taken)
//   if_rdata/if_ready   fetched word and its one-cycle completion pulse
//   mem_rd_en/mem_wr_en MEM read / write request (both high = write)
//   mem_addr/mem_wdata  MEM address and write data
//   mem_rdata/mem_ready MEM read data and its one-cycle completion pulse
//   sram_*              registered SRAM interface (ce_n/we_n active low)
//   busy                high whenever the sequencer is not idle
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_rd_en,
  input  logic              mem_wr_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       owner_mem;
  logic       is_write;
  logic       cancel_flag;

  // Single sequencer. Every output is a register, updated together with the state.
  // A cancel seen on the final ACCESS edge must also suppress the IF result.
  // That is why the live if_cancel is ORed with cancel_flag at completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      owner_mem   <= 1'b0;
      is_write    <= 1'b0;
      cancel_flag <= 1'b0;
      if_ready    <= 1'b0;
      mem_ready   <= 1'b0;
      if_rdata    <= '0;
      mem_rdata   <= '0;
      sram_addr   <= '0;
      sram_wdata  <= '0;
      sram_ce_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if_ready  <= 1'b0;
          mem_ready <= 1'b0;
          if (mem_rd_en || mem_wr_en) begin
            owner_mem   <= 1'b1;
            is_write    <= mem_wr_en;
            sram_addr   <= mem_addr;
            if (mem_wr_en)
              sram_wdata <= mem_wdata;
            sram_ce_n   <= 1'b0;
            sram_we_n   <= ~mem_wr_en;
            cnt         <= CNT_LOAD;
            cancel_flag <= 1'b0;
            state       <= ACCESS;
            busy        <= 1'b1;
          end else if (if_req) begin
            owner_mem   <= 1'b0;
            is_write    <= 1'b0;
            sram_addr   <= if_addr;
            sram_ce_n   <= 1'b0;
            sram_we_n   <= 1'b1;
            cnt         <= CNT_LOAD;
            cancel_flag <= if_cancel;
            state       <= ACCESS;
            busy        <= 1'b1;
          end
        end

        ACCESS: begin
          if (!owner_mem && if_cancel)
            cancel_flag <= 1'b1;
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            sram_ce_n <= 1'b1;
            sram_we_n <= 1'b1;
            if (owner_mem) begin
              if (!is_write)
                mem_rdata <= sram_rdata;
              mem_ready <= 1'b1;
            end else if (!(cancel_flag || if_cancel)) begin
              if_rdata <= sram_rdata;
              if_ready <= 1'b1;
            end
            state <= DONE;
          end
        end

        // No grant here, so a request still held during the ready cycle is not served twice.
        DONE: begin
          if_ready  <= 1'b0;
          mem_ready <= 1'b0;
          state     <= IDLE;
          busy      <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with WAIT_CYCLES=3. The bench drives the
// inputs 1 ns after each rising edge and samples the registered outputs at the
// same point. Edge 0 is the grant edge of each transfer.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_cancel, mem_rd_en, mem_wr_en;
  logic [31:0] if_addr, mem_addr, mem_wdata, sram_rdata;
  logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata;
  logic        if_ready, mem_ready, sram_ce_n, sram_we_n, busy;

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_ce_n(sram_ce_n),
    .sram_we_n(sram_we_n), .sram_rdata(sram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr, input logic icancel,
                               input logic rd, input logic wr, input logic [31:0] maddr,
                               input logic [31:0] wdata, input logic [31:0] srd);
    if_req     = ireq;
    if_addr    = iaddr;
    if_cancel  = icancel;
    mem_rd_en  = rd;
    mem_wr_en  = wr;
    mem_addr   = maddr;
    mem_wdata  = wdata;
    sram_rdata = srd;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " ce_n"}, 32'(sram_ce_n), 32'd1);
    checkOutput({tag, " we_n"}, 32'(sram_we_n), 32'd1);
    checkOutput({tag, " if_ready"}, 32'(if_ready), 32'd0);
    checkOutput({tag, " mem_ready"}, 32'(mem_ready), 32'd0);
    checkOutput({tag, " if_rdata"}, if_rdata, 32'd0);
    checkOutput({tag, " mem_rdata"}, mem_rdata, 32'd0);
    checkOutput({tag, " sram_addr"}, sram_addr, 32'd0);
    checkOutput({tag, " sram_wdata"}, sram_wdata, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick(2);
    checkResetState("reset");
    rst = 1'b1;
    tick(1);
    checkOutput("idle busy", 32'(busy), 32'd0);

    // Plain IF read.
    applyStimulus(1, 32'h10, 0, 0, 0, 0, 0, 32'hE3A01005);
    tick(1);
    if_req = 1'b0;
    checkOutput("if ce_n c1", 32'(sram_ce_n), 32'd0);
    checkOutput("if we_n c1", 32'(sram_we_n), 32'd1);
    checkOutput("if addr", sram_addr, 32'h10);
    checkOutput("if busy c1", 32'(busy), 32'd1);
    tick(2);
    checkOutput("if ce_n c3", 32'(sram_ce_n), 32'd0);
    checkOutput("if ready c3", 32'(if_ready), 32'd0);
    tick(1);
    checkOutput("if ready c4", 32'(if_ready), 32'd1);
    checkOutput("if rdata", if_rdata, 32'hE3A01005);
    checkOutput("if ce_n c4", 32'(sram_ce_n), 32'd1);
    tick(1);
    checkOutput("if ready c5", 32'(if_ready), 32'd0);
    checkOutput("if busy c5", 32'(busy), 32'd0);

    // IF and MEM together: MEM first, IF in the following idle cycle.
    applyStimulus(1, 32'h20, 0, 1, 0, 32'h400, 0, 32'h0000002A);
    tick(1);
    checkOutput("prio addr", sram_addr, 32'h400);
    tick(3);
    checkOutput("prio mem_ready c4", 32'(mem_ready), 32'd1);
    checkOutput("prio mem_rdata", mem_rdata, 32'h2A);
    checkOutput("prio if_ready c4", 32'(if_ready), 32'd0);
    sram_rdata = 32'h11112222;
    tick(1);
    mem_rd_en = 1'b0;
    checkOutput("prio mem_ready c5", 32'(mem_ready), 32'd0);
    checkOutput("prio busy c5", 32'(busy), 32'd0);
    tick(1);
    if_req = 1'b0;
    checkOutput("prio if addr", sram_addr, 32'h20);
    checkOutput("prio busy c6", 32'(busy), 32'd1);
    tick(2);
    checkOutput("prio if_ready c8", 32'(if_ready), 32'd0);
    tick(1);
    checkOutput("prio if_ready c9", 32'(if_ready), 32'd1);
    checkOutput("prio if_rdata", if_rdata, 32'h11112222);
    tick(1);
    checkOutput("prio mem_ready stays 0", 32'(mem_ready), 32'd0);

    // MEM write, then read+write together behaves as a write.
    for (int k = 0; k < 2; k++) begin
      logic [31:0] wd;
      logic [31:0] wa;
      wd = (k == 0) ? 32'hDEADBEEF : 32'hCAFEF00D;
      wa = (k == 0) ? 32'h404 : 32'h408;
      applyStimulus(0, 0, 0, (k == 1), 1, wa, wd, 32'h55555555);
      tick(1);
      checkOutput("wr we_n c1", 32'(sram_we_n), 32'd0);
      checkOutput("wr wdata c1", sram_wdata, wd);
      checkOutput("wr addr", sram_addr, wa);
      tick(2);
      checkOutput("wr we_n c3", 32'(sram_we_n), 32'd0);
      checkOutput("wr ce_n c3", 32'(sram_ce_n), 32'd0);
      tick(1);
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      checkOutput("wr mem_ready c4", 32'(mem_ready), 32'd1);
      checkOutput("wr mem_rdata kept", mem_rdata, 32'h2A);
      checkOutput("wr we_n c4", 32'(sram_we_n), 32'd1);
      tick(1);
      checkOutput("wr busy c5", 32'(busy), 32'd0);
    end

    // IF cancelled in cycle 2.
    applyStimulus(1, 32'h30, 0, 0, 0, 0, 0, 32'h77777777);
    tick(1);
    if_req = 1'b0;
    tick(1);
    if_cancel = 1'b1;
    tick(1);
    if_cancel = 1'b0;
    checkOutput("cancel ce_n c2", 32'(sram_ce_n), 32'd0);
    tick(1);
    checkOutput("cancel if_ready c4", 32'(if_ready), 32'd0);
    checkOutput("cancel if_rdata", if_rdata, 32'h11112222);
    tick(1);
    checkOutput("cancel if_ready c5", 32'(if_ready), 32'd0);
    checkOutput("cancel busy c5", 32'(busy), 32'd0);

    // Cancel on the grant edge itself.
    applyStimulus(1, 32'h38, 1, 0, 0, 0, 0, 32'h66666666);
    tick(1);
    if_req = 1'b0;
    if_cancel = 1'b0;
    tick(3);
    checkOutput("gcancel if_ready", 32'(if_ready), 32'd0);
    checkOutput("gcancel if_rdata", if_rdata, 32'h11112222);
    tick(1);

    // Next IF after a cancel is served normally.
    applyStimulus(1, 32'h34, 0, 0, 0, 0, 0, 32'h12345678);
    tick(1);
    if_req = 1'b0;
    tick(3);
    checkOutput("after cancel if_ready", 32'(if_ready), 32'd1);
    checkOutput("after cancel if_rdata", if_rdata, 32'h12345678);
    tick(1);

    // Reset during ACCESS cycle 2, held for two edges.
    applyStimulus(0, 0, 0, 1, 0, 32'h500, 0, 32'h99);
    tick(1);
    checkOutput("mid busy c1", 32'(busy), 32'd1);
    tick(1);
    rst = 1'b0;
    tick(1);
    checkResetState("mid reset e1");
    tick(1);
    mem_rd_en = 1'b0;
    checkResetState("mid reset e2");
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkOutput("post reset mem_ready", 32'(mem_ready), 32'd0);
      checkOutput("post reset ce_n", 32'(sram_ce_n), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
